// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_t;

   localparam int unsigned CNT_W = 4;

   localparam logic [3:0] BE_B0 = 4'b0001;
   localparam logic [3:0] BE_B1 = 4'b0010;
   localparam logic [3:0] BE_B2 = 4'b0100;
   localparam logic [3:0] BE_B3 = 4'b1000;
   localparam logic [3:0] BE_H0 = 4'b0011;
   localparam logic [3:0] BE_H1 = 4'b1100;
   localparam logic [3:0] BE_W  = 4'b1111;

   function automatic logic be_legal(input logic [3:0] be);
      return (be == BE_B0) || (be == BE_B1) || (be == BE_B2) || (be == BE_B3) ||
             (be == BE_H0) || (be == BE_H1) || (be == BE_W);
   endfunction

   // Lowest enabled lane; an empty mask maps to 3 but is rejected by be_legal anyway.
   function automatic logic [1:0] be_lsb(input logic [3:0] be);
      if (be[0])      return 2'd0;
      else if (be[1]) return 2'd1;
      else if (be[2]) return 2'd2;
      else            return 2'd3;
   endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-wide storage with per-byte write enables, synchronous write and
// combinational read. Contents are deliberately left unreset.
module dm_ram
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Slave end of the CPU load/store port: one request at a time, LATENCY wait
// states between accept and commit, response held until the CPU takes it.
module dm_responder
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam bit ZERO_LAT = (LATENCY == 0);
   localparam logic [CNT_W-1:0] LAT_LOAD = ZERO_LAT ? '0 : CNT_W'(LATENCY - 1);

   dm_state_t        state, state_nx;
   logic [CNT_W-1:0] cnt;

   logic             lat_we;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_wdata;
   logic [3:0]       lat_be;

   logic             accept;
   logic             commit;
   logic             c_we;
   logic [31:0]      c_addr;
   logic [31:0]      c_wdata;
   logic [3:0]       c_be;
   logic             c_err;
   logic             ram_we;
   logic [31:0]      ram_rdata;

   assign req_ready = reset && (state == IDLE);
   assign accept    = req_valid && req_ready;

   // With no wait states the commit coincides with the accept edge, so the
   // request is taken straight from the port instead of the latch.
   assign c_we    = ZERO_LAT ? req_we    : lat_we;
   assign c_addr  = ZERO_LAT ? req_addr  : lat_addr;
   assign c_wdata = ZERO_LAT ? req_wdata : lat_wdata;
   assign c_be    = ZERO_LAT ? req_be    : lat_be;

   always_comb begin
      c_err = (c_addr[31:ADDR_W+2] != '0);
      if (c_we && (!be_legal(c_be) || (be_lsb(c_be) != c_addr[1:0]))) c_err = 1'b1;
   end

   assign ram_we = commit && c_we && !c_err;

   dm_ram #(
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (c_be),
      .addr  (c_addr[ADDR_W+1:2]),
      .wdata (c_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      commit   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (ZERO_LAT) begin
                  commit   = 1'b1;
                  state_nx = RESP;
               end else begin
                  state_nx = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               commit   = 1'b1;
               state_nx = RESP;
            end
         end
         RESP: begin
            if (resp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
      end else begin
         if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= LAT_LOAD;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (commit) begin
         resp_valid <= 1'b1;
         resp_err   <= c_err;
         resp_rdata <= (c_err || c_we) ? '0 : ram_rdata;
      end else if ((state == RESP) && resp_ready) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end
   end

endmodule
